// File: rtl/freq_div_prog.sv
// freq_div_prog
// Programmable divider clocked directly by the VCO (Fin). A single phase
// counter produces Fout with a period of R_act Fin cycles. The high phase
// lasts H_act = R_act>>1 cycles. New ratios are staged in a shadow register
// and only take effect at a period boundary, so Fout never glitches. A stop
// request is also deferred to a period boundary, so the last pulse is never cut.
//
// Ports
//   Fin     in   VCO clock, rising edge only
//   Resetn  in   asynchronous active-low reset
//   Enable  in   run request
//   Load    in   one-cycle strobe capturing Mode/Fsel/Div
//   Mode    in   0: R = 2^min(Fsel+1,WIDTH), 1: R = max(Div,2)
//   Fsel    in   power-of-two selector
//   Div     in   integer divide ratio
//   Fout    out  divided clock (registered)
//   Tick    out  one-cycle pulse with every Fout rising edge (registered)
//   Ack     out  one-cycle pulse when a loaded ratio becomes active (registered)
//   Busy    out  high while running (decoded straight from the state register)
module freq_div_prog #(
    parameter int WIDTH = 16,
    parameter int SELW  = 4
) (
    input  logic             Fin,
    input  logic             Resetn,
    input  logic             Enable,
    input  logic             Load,
    input  logic             Mode,
    input  logic [SELW-1:0]  Fsel,
    input  logic [WIDTH-1:0] Div,
    output logic             Fout,
    output logic             Tick,
    output logic             Ack,
    output logic             Busy
);

    // Ratios need one extra bit so that 2^WIDTH is representable.
    localparam int RW = WIDTH + 1;
    localparam logic [RW-1:0] R_MIN = RW'(2);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Turn the control word into a division ratio. The power-of-two exponent
    // saturates at WIDTH, and integer ratios below 2 are forced to 2.
    function automatic logic [RW-1:0] decode_ratio(
        input logic             mode,
        input logic [SELW-1:0]  fsel,
        input logic [WIDTH-1:0] div
    );
        logic [RW-1:0] r;
        int            e;
        r = R_MIN;
        e = 0;
        if (mode == 1'b0) begin
            e = int'(fsel) + 32'sd1;
            if (e > WIDTH) begin
                e = WIDTH;
            end else begin
                e = e;
            end
            r = RW'(1) << e;
        end else begin
            if (div < WIDTH'(2)) begin
                r = R_MIN;
            end else begin
                r = {1'b0, div};
            end
        end
        return r;
    endfunction

    state_t           state_r, state_n;
    logic [WIDTH-1:0] cnt_r, cnt_n;
    logic [RW-1:0]    r_act_r, r_act_n;
    logic [RW-1:0]    r_sh_r, r_sh_n;
    logic             pend_r, pend_n;
    logic             fout_r, fout_n;
    logic             tick_r, tick_n;
    logic             ack_r, ack_n;

    logic [RW-1:0]    dec_s;
    logic [WIDTH-1:0] cnt_inc_s;
    logic             wrap_s;

    assign dec_s     = decode_ratio(Mode, Fsel, Div);
    assign cnt_inc_s = cnt_r + WIDTH'(1);
    // Last cycle of the current output period.
    assign wrap_s    = (state_r == RUN) && ({1'b0, cnt_r} == (r_act_r - RW'(1)));

    // Next-state, counter, ratio bookkeeping and output decode.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        r_act_n = r_act_r;
        r_sh_n  = r_sh_r;
        pend_n  = pend_r;
        fout_n  = fout_r;
        tick_n  = 1'b0;
        ack_n   = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_n  = '0;
                fout_n = 1'b0;
                tick_n = 1'b0;
                // While idle every edge is a safe boundary. A Load that meets an
                // already pending ratio replaces it and is applied at once.
                if (Load && pend_r) begin
                    r_act_n = dec_s;
                    pend_n  = 1'b0;
                    ack_n   = 1'b1;
                end else if (Load) begin
                    r_sh_n = dec_s;
                    pend_n = 1'b1;
                end else if (pend_r) begin
                    r_act_n = r_sh_r;
                    pend_n  = 1'b0;
                    ack_n   = 1'b1;
                end else begin
                    pend_n = pend_r;
                end
                if (Enable) begin
                    state_n = RUN;
                    cnt_n   = '0;
                    fout_n  = 1'b1;
                    tick_n  = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            RUN: begin
                if (wrap_s) begin
                    // A new period starts high, whatever the new ratio is (H >= 1).
                    cnt_n  = '0;
                    fout_n = 1'b1;
                    tick_n = 1'b1;
                    if (Load) begin
                        r_act_n = dec_s;
                        pend_n  = 1'b0;
                        ack_n   = 1'b1;
                    end else if (pend_r) begin
                        r_act_n = r_sh_r;
                        pend_n  = 1'b0;
                        ack_n   = 1'b1;
                    end else begin
                        pend_n = pend_r;
                    end
                    if (!Enable) begin
                        state_n = IDLE;
                        fout_n  = 1'b0;
                        tick_n  = 1'b0;
                    end else begin
                        state_n = RUN;
                    end
                end else begin
                    cnt_n  = cnt_inc_s;
                    fout_n = ({1'b0, cnt_inc_s} < (r_act_r >> 1));
                    tick_n = 1'b0;
                    if (Load) begin
                        r_sh_n = dec_s;
                        pend_n = 1'b1;
                    end else begin
                        pend_n = pend_r;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                fout_n  = 1'b0;
                tick_n  = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge Fin or negedge Resetn) begin
        if (!Resetn) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            r_act_r <= R_MIN;
            r_sh_r  <= R_MIN;
            pend_r  <= 1'b0;
            fout_r  <= 1'b0;
            tick_r  <= 1'b0;
            ack_r   <= 1'b0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            r_act_r <= r_act_n;
            r_sh_r  <= r_sh_n;
            pend_r  <= pend_n;
            fout_r  <= fout_n;
            tick_r  <= tick_n;
            ack_r   <= ack_n;
        end
    end

    assign Fout = fout_r;
    assign Tick = tick_r;
    assign Ack  = ack_r;
    assign Busy = (state_r == RUN);

endmodule
